// File: rtl/fetch_stage.sv
// Instruction-fetch stage for a 5-stage RV32I pipeline.
// Owns the PC, presents it to the instruction memory and captures the
// returned word into the IF/ID register. Handles stall, redirects with
// bubble insertion, and halting once an EBREAK has been fetched.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP      = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [31:0]       if_id_inst,
    output logic              misalign,
    output logic              halted
);

    localparam logic [31:0]       EBREAK = 32'h0010_0073;
    localparam logic [ADDR_W-1:0] FOUR   = ADDR_W'(4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic              valid_q,    valid_d;
    logic [ADDR_W-1:0] id_pc_q,    id_pc_d;
    logic [ADDR_W-1:0] id_pc4_q,   id_pc4_d;
    logic [31:0]       id_inst_q,  id_inst_d;
    logic              misalign_q, misalign_d;

    // PC arithmetic is ADDR_W bits wide, so 0xFC + 4 wraps to 0x00.
    logic [ADDR_W-1:0] pc_plus4;
    assign pc_plus4 = pc_q + FOUR;

    // Next-state selection: redirect beats stall, stall beats RUN/HALT.
    always_comb begin
        // NOTE: every target gets a hold value first so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_inst_d  = id_inst_q;
        misalign_d = misalign_q;

        if (redirect_valid) begin
            // Low address bits are dropped so the PC stays word aligned;
            // a non-zero offset is remembered in the sticky misalign flag.
            pc_d      = {redirect_target[ADDR_W-1:2], 2'b00};
            valid_d   = 1'b0;
            id_inst_d = NOP;
            state_d   = RUN;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            // Everything holds (defaults above).
        end else if (state_q == RUN) begin
            valid_d   = 1'b1;
            id_pc_d   = pc_q;
            id_pc4_d  = pc_plus4;
            id_inst_d = imem_data;
            if (imem_data == EBREAK) begin
                // EBREAK itself is passed on; fetch stops at its address.
                state_d = HALT;
            end else begin
                pc_d = pc_plus4;
            end
        end else begin
            // HALT: keep feeding bubbles until a redirect or reset.
            valid_d   = 1'b0;
            id_inst_d = NOP;
        end
    end

    // State and IF/ID register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_inst_q  <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_inst_q  <= id_inst_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign if_id_inst  = id_inst_q;
    assign misalign    = misalign_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 64-word instruction memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [7:0]  if_id_pc;
    logic [7:0]  if_id_pc4;
    logic [31:0] if_id_inst;
    logic        misalign;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] imem [64];
    assign imem_data = imem[imem_addr[7:2]];

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (8),
        .RESET_PC (8'h00),
        .NOP      (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_inst      (if_id_inst),
        .misalign        (misalign),
        .halted          (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"},    32'(if_id_valid), 32'd0);
        check({tag, " inst"},     if_id_inst,       32'h0000_0013);
        check({tag, " pc"},       32'(if_id_pc),    32'h00);
        check({tag, " pc4"},      32'(if_id_pc4),   32'h00);
        check({tag, " misalign"}, 32'(misalign),    32'd0);
        check({tag, " halted"},   32'(halted),      32'd0);
        check({tag, " imem_addr"},32'(imem_addr),   32'h00);
    endtask

    initial begin
        // Word i holds addi x2,x0,i; word 0 and word 4 (0x10) are special.
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0113 | (32'(i) << 20);
        imem[0] = 32'h0050_0093;
        imem[4] = 32'h0010_0073;

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;

        // T1: reset for two cycles, then first fetch
        tick(); tick();
        check_reset_state("rst");
        rst = 1'b0;
        tick();
        check("t1 valid", 32'(if_id_valid), 32'd1);
        check("t1 pc",    32'(if_id_pc),    32'h00);
        check("t1 pc4",   32'(if_id_pc4),   32'h04);
        check("t1 inst",  if_id_inst,       32'h0050_0093);
        check("t1 addr",  32'(imem_addr),   32'h04);

        // T2/T3: fetch 0x4, then stall three cycles at pc=8, then 0x8 and 0xC
        tick();
        check("t2 pc4",  32'(if_id_pc),  32'h04);
        check("t2 pc4b", 32'(if_id_pc4), 32'h08);
        check("t2 inst", if_id_inst,     32'h0010_0113);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3 addr",  32'(imem_addr),   32'h08);
            check("t3 pc",    32'(if_id_pc),    32'h04);
            check("t3 inst",  if_id_inst,       32'h0010_0113);
            check("t3 valid", 32'(if_id_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        check("t2 pc8",   32'(if_id_pc),  32'h08);
        check("t2 pc8b",  32'(if_id_pc4), 32'h0C);
        check("t2 inst8", if_id_inst,     32'h0020_0113);
        tick();
        check("t2 pcC",   32'(if_id_pc),  32'h0C);
        check("t2 pcCb",  32'(if_id_pc4), 32'h10);
        check("t2 instC", if_id_inst,     32'h0030_0113);
        check("t2 addr",  32'(imem_addr), 32'h10);

        // T4: redirect overrides stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        check("t4 addr",     32'(imem_addr),   32'h40);
        check("t4 valid",    32'(if_id_valid), 32'd0);
        check("t4 inst",     if_id_inst,       32'h0000_0013);
        check("t4 misalign", 32'(misalign),    32'd0);
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        check("t4 pc",   32'(if_id_pc),    32'h40);
        check("t4 inst2",if_id_inst,       32'h0100_0113);
        check("t4 valid2",32'(if_id_valid),32'd1);
        check("t4 addr2",32'(imem_addr),   32'h44);

        // T5: EBREAK at 0x10 halts, redirect to 0x20 resumes
        redirect_valid = 1'b1; redirect_target = 8'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t5 inst",   if_id_inst,       32'h0010_0073);
        check("t5 valid",  32'(if_id_valid), 32'd1);
        check("t5 halted", 32'(halted),      32'd1);
        check("t5 addr",   32'(imem_addr),   32'h10);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t5 bubble valid", 32'(if_id_valid), 32'd0);
            check("t5 bubble inst",  if_id_inst,       32'h0000_0013);
            check("t5 hold halted",  32'(halted),      32'd1);
            check("t5 hold addr",    32'(imem_addr),   32'h10);
        end
        redirect_valid = 1'b1; redirect_target = 8'h20;
        tick();
        check("t5 unhalt",  32'(halted),    32'd0);
        check("t5 re addr", 32'(imem_addr), 32'h20);
        redirect_valid = 1'b0;
        tick();
        check("t5 re pc",   32'(if_id_pc),    32'h20);
        check("t5 re inst", if_id_inst,       32'h0080_0113);
        check("t5 re valid",32'(if_id_valid), 32'd1);

        // T6: wrap at 0xFC, then misaligned redirect
        redirect_valid = 1'b1; redirect_target = 8'hFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t6 pc",   32'(if_id_pc),  32'hFC);
        check("t6 pc4",  32'(if_id_pc4), 32'h00);
        check("t6 inst", if_id_inst,     32'h03F0_0113);
        check("t6 addr", 32'(imem_addr), 32'h00);
        redirect_valid = 1'b1; redirect_target = 8'h43;
        tick();
        redirect_valid = 1'b0;
        check("t6 mis addr", 32'(imem_addr), 32'h40);
        check("t6 misalign", 32'(misalign),  32'd1);
        tick(); tick();
        check("t6 sticky",      32'(misalign),  32'd1);
        check("t6 sticky addr", 32'(imem_addr), 32'h48);

        // Reset while halted, with stall and redirect asserted, wins outright
        redirect_valid = 1'b1; redirect_target = 8'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        check("pre-rst halted", 32'(halted), 32'd1);
        rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h80;
        tick();
        check_reset_state("rst2");
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        tick();
        check("post-rst inst", if_id_inst,     32'h0050_0093);
        check("post-rst addr", 32'(imem_addr), 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
